elevator_ctrl: RTL and testbench



---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_ctrl_if.sv | 33 +++
 rtl/elevator_ctrl_req_scan.sv | 31 +++
 rtl/elevator_ctrl.sv | 164 ++++++++++++++++
 tb/tb_elevator_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants for the elevator car scheduler
// Contents: FSM state encoding, the "no floor" marker, default floor count.
package elevator_pkg;

  localparam int DEF_FLOORS = 8;

  // 4'hF can never be a real floor (at most 15 floors, numbered 0..14).
  localparam logic [3:0] NO_FLOOR = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_OPEN = 2'd2;

endpackage

// File: rtl/elevator_ctrl_if.sv
// rtl/elevator_ctrl_if.sv - request/clear bus between button register and car scheduler
// Signals:
//   active_in/out_up/out_down_levels      latched requests (button register -> scheduler)
//   inactivate_in/out_up/out_down_levels  one-cycle clear pulses (scheduler -> button register)
//   buttons_blocked                       floor whose buttons are ignored while the door is open
// Modports: master = button register side, slave = scheduler side.
interface elevator_ctrl_if
  import elevator_pkg::*;
#(
  parameter int FLOORS = DEF_FLOORS
);

  logic [FLOORS-1:0] active_in_levels;
  logic [FLOORS-1:0] active_out_up_levels;
  logic [FLOORS-1:0] active_out_down_levels;
  logic [FLOORS-1:0] inactivate_in_levels;
  logic [FLOORS-1:0] inactivate_out_up_levels;
  logic [FLOORS-1:0] inactivate_out_down_levels;
  logic [3:0]        buttons_blocked;

  modport master (
    output active_in_levels, active_out_up_levels, active_out_down_levels,
    input  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
    input  buttons_blocked
  );

  modport slave (
    input  active_in_levels, active_out_up_levels, active_out_down_levels,
    output inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
    output buttons_blocked
  );

endinterface

// File: rtl/elevator_ctrl_req_scan.sv
// rtl/elevator_ctrl_req_scan.sv - combinational request scan around one floor
// Ports:
//   req    in   combined request vector, one bit per floor
//   floor  in   reference floor
//   above  out  any request strictly above floor
//   below  out  any request strictly below floor
//   here   out  request at floor
module req_scan
  import elevator_pkg::*;
#(
  parameter int FLOORS = DEF_FLOORS
) (
  input  logic [FLOORS-1:0] req,
  input  logic [3:0]        floor,
  output logic              above,
  output logic              below,
  output logic              here
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(floor))  above = above | req[i];
      if (i < int'(floor))  below = below | req[i];
      if (i == int'(floor)) here  = req[i];
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - collective (SCAN) car scheduler with motion and door sequencing
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   door_obstructed  holds the door open while high
//   bus              request/clear bus (slave side)
//   current_floor    car position
//   dir_up           travel direction, 1 = up
//   moving           car travelling between floors
//   door_open        door open at current_floor
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS        = DEF_FLOORS,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int CW            = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            door_obstructed,
  elevator_ctrl_if.slave  bus,
  output logic [3:0]      current_floor,
  output logic            dir_up,
  output logic            moving,
  output logic            door_open
);

  localparam logic [3:0]    TOP         = 4'(FLOORS - 1);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [FLOORS-1:0] pulse_in, pulse_up, pulse_dn;

  logic [FLOORS-1:0] req, floor_mask;
  logic [FLOORS-1:0] svc_in, svc_up, svc_dn;
  logic [3:0]        next_floor, sel_floor;
  logic              arriving, sel_dir;
  logic              above, below, here;
  logic              in_f, up_f, dn_f;
  logic              ahead, behind, new_dir, stop_here, svc_any;

  assign req        = bus.active_in_levels | bus.active_out_up_levels | bus.active_out_down_levels;
  assign arriving   = (state == ST_MOVE) && (count == '0);
  assign next_floor = dir_up ? current_floor + 4'd1 : current_floor - 4'd1;

  // On the arrival edge every decision is taken for the floor being entered,
  // with the direction already turned around at the end floors.
  assign sel_floor = arriving ? next_floor : current_floor;

  always_comb begin
    sel_dir = dir_up;
    if (arriving) begin
      if (next_floor == TOP)       sel_dir = 1'b0;
      else if (next_floor == 4'd0) sel_dir = 1'b1;
    end
  end

  req_scan #(.FLOORS(FLOORS)) u_scan (
    .req   (req),
    .floor (sel_floor),
    .above (above),
    .below (below),
    .here  (here)
  );

  always_comb begin
    floor_mask = '0;
    for (int i = 0; i < FLOORS; i++) floor_mask[i] = (4'(i) == sel_floor);
  end

  assign in_f    = |(bus.active_in_levels & floor_mask);
  assign up_f    = |(bus.active_out_up_levels & floor_mask);
  assign dn_f    = |(bus.active_out_down_levels & floor_mask);
  assign ahead   = sel_dir ? above : below;
  assign behind  = sel_dir ? below : above;
  assign new_dir = (!ahead && behind) ? !sel_dir : sel_dir;

  // A hall call against the travel direction is only served when nothing is
  // left ahead; otherwise it waits for the return sweep. The same rule gates
  // opening from IDLE, so such a call never cycles the door without moving.
  assign stop_here = in_f | (sel_dir ? up_f : dn_f) | (!ahead && here);

  // A vector pulsed last cycle stays quiet this cycle so the button register
  // always sees a fresh rising edge.
  assign svc_in = (pulse_in == '0) ? (bus.active_in_levels & floor_mask) : '0;
  assign svc_up = (pulse_up == '0 && (sel_dir || !ahead)) ? (bus.active_out_up_levels & floor_mask) : '0;
  assign svc_dn = (pulse_dn == '0 && (!sel_dir || !ahead)) ? (bus.active_out_down_levels & floor_mask) : '0;
  assign svc_any = |{svc_in, svc_up, svc_dn};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      current_floor <= 4'd0;
      dir_up        <= 1'b1;
      pulse_in      <= '0;
      pulse_up      <= '0;
      pulse_dn      <= '0;
    end else begin
      pulse_in <= '0;
      pulse_up <= '0;
      pulse_dn <= '0;
      case (state)
        ST_IDLE: begin
          if (stop_here) begin
            state    <= ST_OPEN;
            count    <= DOOR_LOAD;
            dir_up   <= new_dir;
            pulse_in <= svc_in;
            pulse_up <= svc_up;
            pulse_dn <= svc_dn;
          end else if (ahead) begin
            state <= ST_MOVE;
            count <= TRAVEL_LOAD;
          end else if (behind) begin
            state  <= ST_MOVE;
            count  <= TRAVEL_LOAD;
            dir_up <= !dir_up;
          end
        end
        ST_MOVE: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            current_floor <= next_floor;
            if (stop_here) begin
              state    <= ST_OPEN;
              count    <= DOOR_LOAD;
              dir_up   <= new_dir;
              pulse_in <= svc_in;
              pulse_up <= svc_up;
              pulse_dn <= svc_dn;
            end else begin
              count  <= TRAVEL_LOAD;
              dir_up <= sel_dir;
            end
          end
        end
        ST_OPEN: begin
          if (svc_any) begin
            dir_up   <= new_dir;
            pulse_in <= svc_in;
            pulse_up <= svc_up;
            pulse_dn <= svc_dn;
          end
          if (door_obstructed || svc_any) count <= DOOR_LOAD;
          else if (count == '0)           state <= ST_IDLE;
          else                            count <= count - CW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign moving                         = (state == ST_MOVE);
  assign door_open                      = (state == ST_OPEN);
  assign bus.buttons_blocked            = door_open ? current_floor : NO_FLOOR;
  assign bus.inactivate_in_levels       = pulse_in;
  assign bus.inactivate_out_up_levels   = pulse_up;
  assign bus.inactivate_out_down_levels = pulse_dn;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - self-checking bench for elevator_ctrl
module tb_elevator_ctrl;

  localparam int F  = 8;
  localparam int TC = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst, obst;
  logic [7:0] a_in, a_up, a_dn;
  logic [3:0] cf;
  logic       dir_up, moving, door_open;

  always #5 clk = ~clk;

  elevator_ctrl_if #(.FLOORS(F)) bus ();
  assign bus.active_in_levels       = a_in;
  assign bus.active_out_up_levels   = a_up;
  assign bus.active_out_down_levels = a_dn;

  elevator_ctrl #(.FLOORS(F), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .CW(8)) dut (
    .clk             (clk),
    .reset           (rst),
    .door_obstructed (obst),
    .bus             (bus),
    .current_floor   (cf),
    .dir_up          (dir_up),
    .moving          (moving),
    .door_open       (door_open)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int       m_floor, m_el;
  bit       m_up, m_mov, m_open;
  bit [7:0] m_pi, m_pu, m_pd;

  function automatic bit bit_at(input bit [7:0] v, input int f);
    return ((v >> f) & 8'd1) != 0;
  endfunction

  function automatic bit any_side(input bit [7:0] v, input int f, input bit upward);
    for (int i = 0; i < F; i++)
      if ((upward ? (i > f) : (i < f)) && bit_at(v, i)) return 1'b1;
    return 1'b0;
  endfunction

  // Which buttons at floor f a stop serves when travelling in direction d.
  task automatic m_service(input int f, input bit d,
                           output bit [7:0] pi, output bit [7:0] pu, output bit [7:0] pd,
                           output bit nd);
    bit [7:0] req;
    bit [7:0] one;
    bit ahead, behind;
    req    = a_in | a_up | a_dn;
    one    = 8'(1 << f);
    ahead  = any_side(req, f, d);
    behind = any_side(req, f, !d);
    pi = bit_at(a_in, f) ? one : 8'h00;
    pu = ((d || !ahead) && bit_at(a_up, f)) ? one : 8'h00;
    pd = ((!d || !ahead) && bit_at(a_dn, f)) ? one : 8'h00;
    if (m_pi != 0) pi = 8'h00;
    if (m_pu != 0) pu = 8'h00;
    if (m_pd != 0) pd = 8'h00;
    nd = (!ahead && behind) ? !d : d;
  endtask

  task automatic model_step();
    bit [7:0] pi, pu, pd, req;
    bit nd;
    pi = 0; pu = 0; pd = 0;
    req = a_in | a_up | a_dn;
    if (rst) begin
      m_floor = 0; m_up = 1; m_mov = 0; m_open = 0; m_el = 0;
    end else if (!m_mov && !m_open) begin
      m_service(m_floor, m_up, pi, pu, pd, nd);
      if ((pi | pu | pd) != 0) begin
        m_open = 1; m_el = 0; m_up = nd;
      end else if (any_side(req, m_floor, m_up)) begin
        m_mov = 1; m_el = 0;
      end else if (any_side(req, m_floor, !m_up)) begin
        m_mov = 1; m_el = 0; m_up = !m_up;
      end
    end else if (m_mov) begin
      if (m_el < TC - 1) m_el++;
      else begin
        m_floor += m_up ? 1 : -1;
        if (m_floor == F - 1) m_up = 0;
        else if (m_floor == 0) m_up = 1;
        m_service(m_floor, m_up, pi, pu, pd, nd);
        m_el = 0;
        if ((pi | pu | pd) != 0) begin
          m_mov = 0; m_open = 1; m_up = nd;
        end
      end
    end else begin
      m_service(m_floor, m_up, pi, pu, pd, nd);
      if ((pi | pu | pd) != 0) m_up = nd;
      if (obst || (pi | pu | pd) != 0) m_el = 0;
      else if (m_el == DC - 1) m_open = 0;
      else m_el++;
    end
    m_pi = pi; m_pu = pu; m_pd = pd;
  endtask

  // One clock: model advances with the DUT, outputs checked at the falling
  // edge, then the button register clears whatever the model says was served.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("floor",    cf,                    m_floor);
    chk("dir",      dir_up,                m_up);
    chk("moving",   moving,                m_mov);
    chk("door",     door_open,             m_open);
    chk("blocked",  bus.buttons_blocked,   m_open ? m_floor : 32'hF);
    chk("inact_in", bus.inactivate_in_levels,       m_pi);
    chk("inact_up", bus.inactivate_out_up_levels,   m_pu);
    chk("inact_dn", bus.inactivate_out_down_levels, m_pd);
    a_in = a_in & ~m_pi;
    a_up = a_up & ~m_pu;
    a_dn = a_dn & ~m_pd;
  endtask

  task automatic do_reset();
    rst = 1; obst = 0; a_in = 0; a_up = 0; a_dn = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (!moving && !door_open && (a_in | a_up | a_dn) == 0) begin ok = 1; break; end
      tick();
    end
    chk("wait_idle", ok, 1);
  endtask

  int         s_cnt, max_floor;
  int         s_floor[4];
  logic [7:0] s_pi[4], s_pu[4], s_pd[4];
  logic       s_dir[4];

  task automatic collect_stops(input int n, input int limit);
    logic prev;
    s_cnt = 0; max_floor = int'(cf); prev = door_open;
    for (int i = 0; i < limit && s_cnt < n; i++) begin
      tick();
      if (int'(cf) > max_floor) max_floor = int'(cf);
      if (door_open && !prev) begin
        s_floor[s_cnt] = int'(cf);
        s_pi[s_cnt] = bus.inactivate_in_levels;
        s_pu[s_cnt] = bus.inactivate_out_up_levels;
        s_pd[s_cnt] = bus.inactivate_out_down_levels;
        s_dir[s_cnt] = dir_up;
        s_cnt++;
      end
      prev = door_open;
    end
    chk("stop_count", s_cnt, n);
  endtask

  typedef struct {
    logic [7:0] in, up, dn;
    logic       mv, dr;
    logic [7:0] ei, eu, ed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    tbl[0] = '{8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00};
    tbl[1] = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00};
    tbl[2] = '{8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01};
    tbl[3] = '{8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{8'h01, 8'h02, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00};
    tbl[7] = '{8'h04, 8'h01, 8'h01, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00};

    m_floor = 0; m_up = 1; m_mov = 0; m_open = 0; m_el = 0;
    m_pi = 0; m_pu = 0; m_pd = 0;

    // reset state
    do_reset();
    chk("rst_floor", cf, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_blocked", bus.buttons_blocked, 4'hF);

    // first decision from idle at floor 0
    for (int k = 0; k < 8; k++) begin
      do_reset();
      a_in = tbl[k].in; a_up = tbl[k].up; a_dn = tbl[k].dn;
      tick();
      chk($sformatf("tbl%0d_moving", k), moving, tbl[k].mv);
      chk($sformatf("tbl%0d_door", k), door_open, tbl[k].dr);
      chk($sformatf("tbl%0d_in", k), bus.inactivate_in_levels, tbl[k].ei);
      chk($sformatf("tbl%0d_up", k), bus.inactivate_out_up_levels, tbl[k].eu);
      chk($sformatf("tbl%0d_dn", k), bus.inactivate_out_down_levels, tbl[k].ed);
      chk($sformatf("tbl%0d_blocked", k), bus.buttons_blocked, tbl[k].dr ? 4'h0 : 4'hF);
    end

    // single trip 0 -> 3
    do_reset();
    a_in = 8'h08;
    tick();
    chk("t1_moving", moving, 1);
    for (int fl = 1; fl <= 3; fl++) begin
      repeat (4) tick();
      chk($sformatf("t1_floor%0d", fl), cf, fl);
    end
    chk("t1_door", door_open, 1);
    chk("t1_pulse", bus.inactivate_in_levels, 8'h08);
    chk("t1_blocked", bus.buttons_blocked, 4'd3);
    tick();
    chk("t1_pulse_off", bus.inactivate_in_levels, 8'h00);
    chk("t1_door2", door_open, 1);
    tick();
    chk("t1_door3", door_open, 1);
    tick();
    chk("t1_closed", door_open, 0);
    chk("t1_blocked_off", bus.buttons_blocked, 4'hF);

    // collective sweep up then down
    do_reset();
    a_in = 8'h20; a_up = 8'h08; a_dn = 8'h04;
    collect_stops(3, 400);
    chk("t2_stop0", s_floor[0], 3);
    chk("t2_up3", s_pu[0], 8'h08);
    chk("t2_stop1", s_floor[1], 5);
    chk("t2_in5", s_pi[1], 8'h20);
    chk("t2_dir5", s_dir[1], 0);
    chk("t2_stop2", s_floor[2], 2);
    chk("t2_dn2", s_pd[2], 8'h04);
    wait_idle(100);

    // hall call at the idle floor, then obstruction
    do_reset();
    a_in = 8'h10;
    wait_idle(200);
    chk("t3_at4", cf, 4);
    a_up = 8'h10;
    tick();
    chk("t3_door", door_open, 1);
    chk("t3_moving", moving, 0);
    chk("t3_pulse", bus.inactivate_out_up_levels, 8'h10);
    chk("t3_floor", cf, 4);
    tick();
    chk("t3_pulse_off", bus.inactivate_out_up_levels, 8'h00);
    obst = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_held", door_open, 1);
    end
    obst = 0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (!door_open) break;
    end
    chk("t4_release", n, 3);

    // reset on the cycle before arrival
    do_reset();
    a_in = 8'h08;
    tick();
    chk("t5_moving", moving, 1);
    repeat (3) tick();
    rst = 1; a_in = 0;
    tick();
    rst = 0;
    chk("t5_floor", cf, 0);
    chk("t5_moving_off", moving, 0);
    chk("t5_door", door_open, 0);
    chk("t5_dir", dir_up, 1);
    chk("t5_blocked", bus.buttons_blocked, 4'hF);
    chk("t5_no_pulse", {bus.inactivate_in_levels, bus.inactivate_out_up_levels,
                        bus.inactivate_out_down_levels}, 0);

    // top floor turnaround
    do_reset();
    a_in = 8'h80;
    wait_idle(200);
    chk("t6_at7", cf, 7);
    chk("t6_dir", dir_up, 0);
    a_dn = 8'h80; a_in = 8'h01;
    collect_stops(2, 300);
    chk("t6_stop0", s_floor[0], 7);
    chk("t6_dn7", s_pd[0], 8'h80);
    chk("t6_stop1", s_floor[1], 0);
    chk("t6_in0", s_pi[1], 8'h01);
    chk("t6_max", max_floor <= 7, 1);
    wait_idle(100);

    // random presses and obstructions against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        int f = $urandom_range(0, F - 1);
        case ($urandom_range(0, 2))
          0:       a_in = a_in | 8'(1 << f);
          1:       a_up = a_up | 8'(1 << f);
          default: a_dn = a_dn | 8'(1 << f);
        endcase
      end
      if (obst) begin
        if ($urandom_range(0, 3) == 0) obst = 0;
      end else if ($urandom_range(0, 99) == 0) obst = 1;
    end
    obst = 0;
    wait_idle(2000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
